// File: rtl/main_control_if.sv
// main_control_if: opcode in, datapath enables and mux selects out.
interface main_control_if;
   logic [5:0] Op;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic [1:0] PCSource, AluOp, AluSrcB;
   logic       AluSrcA, RegWrite, RegDst;
   logic [3:0] State;
   modport master (
      input  Op,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
      output PCSource, AluOp, AluSrcB, AluSrcA, RegWrite, RegDst, State
   );
   modport slave (
      output Op,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
      input  PCSource, AluOp, AluSrcB, AluSrcA, RegWrite, RegDst, State
   );
endinterface

// File: rtl/main_control.sv
// main_control: multicycle MIPS Moore control FSM for lw, sw, R-type, beq, j, addi.
module main_control (
   input logic            clk,
   input logic            reset,
   main_control_if.master bus
);
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
   } state_t;
   state_t state, next;
   always_ff @(posedge clk)
      state <= reset ? FETCH : next;
   always_comb begin
      next = FETCH;
      case (state)
         FETCH:  next = DECODE;
         DECODE: case (bus.Op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXEC;
                    OP_BEQ:       next = BRANCH;
                    OP_J:         next = JUMP;
                    OP_ADDI:      next = ADDIEX;
                    default:      next = FETCH;
                 endcase
         MEMADR: next = (bus.Op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  next = MEMWB;
         EXEC:   next = ALUWB;
         ADDIEX: next = ADDIWB;
         default: next = FETCH;
      endcase
   end
   // Reset masks every output so no write can slip through while the state register settles.
   always_comb begin
      bus.PCWrite = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD = 1'b0;
      bus.MemRead = 1'b0;
      bus.MemWrite = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.IRWrite = 1'b0;
      bus.PCSource = 2'b00;
      bus.AluOp = 2'b00;
      bus.AluSrcB = 2'b00;
      bus.AluSrcA = 1'b0;
      bus.RegWrite = 1'b0;
      bus.RegDst = 1'b0;
      bus.State = reset ? 4'd0 : state;
      if (!reset)
         case (state)
            FETCH: begin
               bus.MemRead = 1'b1;
               bus.IRWrite = 1'b1;
               bus.AluSrcB = 2'b01;
               bus.PCWrite = 1'b1;
            end
            DECODE: bus.AluSrcB = 2'b11;
            MEMADR, ADDIEX: begin
               bus.AluSrcA = 1'b1;
               bus.AluSrcB = 2'b10;
            end
            MEMRD: begin
               bus.MemRead = 1'b1;
               bus.IorD = 1'b1;
            end
            MEMWB: begin
               bus.RegWrite = 1'b1;
               bus.MemtoReg = 1'b1;
            end
            MEMWR: begin
               bus.MemWrite = 1'b1;
               bus.IorD = 1'b1;
            end
            EXEC: begin
               bus.AluSrcA = 1'b1;
               bus.AluOp = 2'b10;
            end
            ALUWB: begin
               bus.RegWrite = 1'b1;
               bus.RegDst = 1'b1;
            end
            ADDIWB: bus.RegWrite = 1'b1;
            BRANCH: begin
               bus.AluSrcA = 1'b1;
               bus.AluOp = 2'b01;
               bus.PCWriteCond = 1'b1;
               bus.PCSource = 2'b01;
            end
            JUMP: begin
               bus.PCWrite = 1'b1;
               bus.PCSource = 2'b10;
            end
            default: bus.State = state;
         endcase
   end
endmodule

// File: tb/tb_main_control.sv
// tb_main_control: scoreboard bench; each driven cycle queues its expected state, a monitor pops and checks.
module tb_main_control;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD = 6'b111111;
   typedef struct {
      logic [3:0] st;
      logic       rst;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_checks = 0;
   int n_pass = 0;
   exp_t q[$];
   main_control_if bus ();
   main_control dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   // Field order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite PCSource AluOp AluSrcB AluSrcA RegWrite RegDst
   function automatic logic [15:0] exp_vec(input logic [3:0] st);
      case (st)
         4'd0:  return 16'b1_0_0_1_0_0_1_00_00_01_0_0_0;
         4'd1:  return 16'b0_0_0_0_0_0_0_00_00_11_0_0_0;
         4'd2:  return 16'b0_0_0_0_0_0_0_00_00_10_1_0_0;
         4'd3:  return 16'b0_0_1_1_0_0_0_00_00_00_0_0_0;
         4'd4:  return 16'b0_0_0_0_0_1_0_00_00_00_0_1_0;
         4'd5:  return 16'b0_0_1_0_1_0_0_00_00_00_0_0_0;
         4'd6:  return 16'b0_0_0_0_0_0_0_00_10_00_1_0_0;
         4'd7:  return 16'b0_0_0_0_0_0_0_00_00_00_0_1_1;
         4'd8:  return 16'b0_1_0_0_0_0_0_01_01_00_1_0_0;
         4'd9:  return 16'b1_0_0_0_0_0_0_10_00_00_0_0_0;
         4'd10: return 16'b0_0_0_0_0_0_0_00_00_10_1_0_0;
         4'd11: return 16'b0_0_0_0_0_0_0_00_00_00_0_1_0;
         default: return 16'h0000;
      endcase
   endfunction
   task automatic step(input logic r, input logic [5:0] op, input logic [3:0] st);
      exp_t e;
      @(negedge clk);
      reset = r;
      bus.Op = op;
      e.st = st;
      e.rst = r;
      q.push_back(e);
   endtask
   // Op is only meaningful in DECODE and MEMADR; drive junk elsewhere to prove it is ignored.
   task automatic run(input logic [5:0] op, input int n, input logic [19:0] seq);
      for (int i = 0; i < n; i++) begin
         logic [3:0] st;
         st = seq[19 - 4*i -: 4];
         step(1'b0, (st == 4'd1 || st == 4'd2) ? op : OP_BAD, st);
      end
   endtask
   always @(negedge clk) begin
      #2;
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         check("state", {12'h0, bus.State}, {12'h0, e.rst ? 4'd0 : e.st});
         check($sformatf("outputs_s%0d_r%0b", e.st, e.rst),
               {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                bus.IRWrite, bus.PCSource, bus.AluOp, bus.AluSrcB, bus.AluSrcA, bus.RegWrite, bus.RegDst},
               e.rst ? 16'h0000 : exp_vec(e.st));
      end
   end
   initial begin
      bus.Op = OP_LW;
      repeat (3) step(1'b1, OP_LW, 4'd0);
      run(OP_LW, 5, 20'h01234);
      run(OP_R, 4, 20'h01670);
      run(OP_BEQ, 3, 20'h01800);
      run(OP_J, 3, 20'h01900);
      run(OP_SW, 4, 20'h01250);
      run(OP_ADDI, 4, 20'h01ab0);
      run(OP_BAD, 2, 20'h01000);
      run(OP_LW, 4, 20'h01230);
      repeat (2) step(1'b1, OP_LW, 4'd0);
      run(OP_R, 4, 20'h01670);
      run(OP_LW, 5, 20'h01234);
      run(OP_SW, 4, 20'h01250);
      repeat (2) @(negedge clk);
      #5;
      if (q.size() != 0) check("queue_drained", 16'(q.size()), 16'h0000);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/main_control.md
# main_control

Multicycle MIPS main control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles and drives every datapath enable and mux select. It consumes the 6-bit opcode from the instruction register and produces `AluOp[1:0]`, which feeds the ALU control decoder directly downstream. It supports lw, sw, R-type, beq, j and addi.

## Interface

Parameters: none (opcode encodings fixed: R 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, j 6'b000010, addi 6'b001000).

- `clk`  input  1  single clock; all state changes on rising edge
- `reset`  input  1  synchronous, active-high reset
- `Op`  input  6  opcode, IR[31:26]
- `PCWrite`  output  1  unconditional PC load
- `PCWriteCond`  output  1  PC load qualified by ALU zero (beq)
- `IorD`  output  1  memory address: 0 = PC, 1 = ALUOut
- `MemRead`  output  1  memory read strobe
- `MemWrite`  output  1  memory write strobe
- `MemtoReg`  output  1  register write data: 0 = ALUOut, 1 = MDR
- `IRWrite`  output  1  instruction register load
- `PCSource`  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `AluOp`  output  2  00 = add, 01 = subtract, 10 = decode funct field
- `AluSrcB`  output  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- `AluSrcA`  output  1  0 = PC, 1 = A
- `RegWrite`  output  1  register file write enable
- `RegDst`  output  1  destination: 0 = rt, 1 = rd
- `State`  output  4  current state encoding, for debug and bench checks

## Operation

- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12-15 are illegal; next state FETCH, all outputs 0.
- Transitions: FETCH -> DECODE. DECODE, by `Op`: lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDIEX; any other opcode -> FETCH (instruction treated as nop, no writes). MEMADR -> MEMRD (lw) or MEMWR (sw). MEMRD -> MEMWB. EXEC -> ALUWB. ADDIEX -> ADDIWB. MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB -> FETCH.
- `Op` is sampled only in DECODE and MEMADR; its value in other states is ignored.
- Outputs are a pure function of registered state; any output not listed below is 0 in that state:
  - FETCH: MemRead=1, IRWrite=1, AluSrcB=01, PCWrite=1 (IorD=0, AluSrcA=0, AluOp=00, PCSource=00)
  - DECODE: AluSrcB=11, AluOp=00
  - MEMADR, ADDIEX: AluSrcA=1, AluSrcB=10, AluOp=00
  - MEMRD: MemRead=1, IorD=1
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0
  - MEMWR: MemWrite=1, IorD=1
  - EXEC: AluSrcA=1, AluSrcB=00, AluOp=10
  - ALUWB: RegWrite=1, RegDst=1, MemtoReg=0
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0
  - BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01
  - JUMP: PCWrite=1, PCSource=10
- At most one of MemRead/MemWrite is 1 in any cycle; RegWrite and MemWrite never both 1.

## Timing

- Reset: on any rising edge with `reset`=1, state <= FETCH. While `reset` is high, all outputs are forced to 0 combinationally (State reads 0), so no PC, IR, memory or register write occurs during reset. First fetch executes in the first cycle after `reset` falls.
- Reset asserted mid-instruction aborts it at that edge; partially completed instruction is not resumed.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R 4, addi 4, beq 3, j 3, undefined opcode 2.
- `AluOp` is valid in the same cycle as the state that drives it; downstream ALU control is combinational, so ALU function settles within that cycle.
- No stall or wait input: memory is assumed single-cycle by the datapath.

## Test plan

- Reset held 3 cycles, then released with Op=lw -> outputs all 0 during reset; State sequence 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4.
- Op=R-type (000000) -> States 0,1,6,7,0; AluOp=10 only in state 6; RegDst=1, RegWrite=1 in state 7.
- Op=beq (000100) then j (000010) -> States 0,1,8,0,1,9,0; state 8: AluOp=01, PCWriteCond=1, PCSource=01; state 9: PCWrite=1, PCSource=10.
- Op=sw then addi -> sw: 0,1,2,5,0 with MemWrite=1, IorD=1 in state 5 and RegWrite never 1; addi: 0,1,10,11,0 with RegDst=0, MemtoReg=0 in state 11.
- Op=6'b111111 -> States 0,1,0; no RegWrite, MemWrite or PCWriteCond in state 1.
- lw in progress, reset asserted in MEMRD -> next edge State=0, outputs 0 while reset high, MEMWB never reached; after release normal fetch resumes.
